param_proc: RTL and testbench
=============================

PARAM_PROC -- requirements
Module: param_proc

Interface
REQ-001 Parameter DW, default 16: data, address and register width; the legal range SHALL be DW >= 9.
REQ-002 Parameter PC_RST, default 0: value loaded into R7 (the pc) on reset.
REQ-003 Clock  input  1  system clock; every state element SHALL update on the rising edge.
REQ-004 Resetn  input  1  reset, synchronous, active-low.
REQ-005 Run  input  1  sampled in T0; 1 starts an instruction fetch.
REQ-006 DIN  input  DW  synchronous memory read data, valid two cycles after ADDR is loaded.
REQ-007 DOUT  output  DW  registered memory write data.
REQ-008 ADDR  output  DW  registered memory address.
REQ-009 W  output  1  registered memory write enable.
REQ-010 Done  output  1  combinational; high in the last cycle of each instruction.

Function
REQ-011 The instruction word SHALL be DIN[8:0], decoded as III XXX YYY, with registers R0..R7 (R7 = pc), each DW bits.
REQ-012 The opcodes SHALL be: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 mvnc.
REQ-013 The FSM SHALL have states T0..T5; T0 SHALL go to T1 on Run and hold otherwise; T1 goes to T2; T2 to T3; T3 to T0 if Done, else T4; T4 to T5; T5 to T0.
REQ-014 In T0, R7 SHALL drive ADDR and the pc SHALL increment if Run=1; in T1, R7 SHALL drive ADDR again; in T2, IR SHALL load.
REQ-015 mv and mvi SHALL complete in T3 (4 cycles); mvi SHALL write DIN to Rx and increment the pc.
REQ-016 add and sub SHALL use T3 for A<-Rx, T4 for G<-A op Ry, and T5 for Rx<-G, completing in 6 cycles.
REQ-017 ld SHALL use T3 for ADDR<-Ry, T4 as a wait cycle, and T5 for Rx<-DIN.
REQ-018 st SHALL use T3 for ADDR<-Ry and T4 for DOUT<-Rx with W set (W visible in T5); Done SHALL assert in T5; W SHALL return to 0 in the cycle after T5.
REQ-019 The ALU SHALL compute modulo 2^DW, so 0xFFFF+1 wraps to 0 at DW=16.
REQ-020 Flag Z SHALL be set to (result==0) whenever G loads; Z SHALL otherwise hold its value.
REQ-021 mvnz SHALL complete in T3 and SHALL write Ry to Rx only if Z=0.
REQ-022 When the destination is R7, a bus load SHALL take priority over the pc increment in the same cycle.
REQ-023 The bus mux SHALL select exactly one of: R0..R7, G or DIN; DIN SHALL be the default.

Reset
REQ-024 With Resetn=0 at a clock edge, the block SHALL set state=T0, R7=PC_RST, W=0, ADDR=0, DOUT=0, Z=0 and C=0; R0..R6, A, G and IR are undefined.
REQ-025 Reset asserted in any state, including mid-st with W=1, SHALL abort the instruction and clear W at that same edge.
REQ-026 Done SHALL be 0 while Tstep is T0..T2.

Configuration
REQ-027 When macro PROC_CARRY_FLAG_EN is defined, the block SHALL implement flag C as the bit-DW carry of the (DW+1)-bit add, or the borrow of the subtract, latched when G loads; mvnc SHALL then write Ry to Rx only if C=0.
REQ-028 When PROC_CARRY_FLAG_EN is undefined, no C register SHALL exist and mvnc SHALL be a no-op that completes in T3.

Structure
REQ-029 Package proc_pkg SHALL hold the opcode constants, the T-state encoding, and the bus-select width.
REQ-030 The pc SHALL be a sub-module named pc_counter, parameterised by DW and PC_RST, with load-over-increment priority.

Verification
REQ-031 The bench SHALL cover: reset, then mvi R0,#5 and mvi R1,#3 -> R0=5, R1=3, pc=4, 4 cycles each.
REQ-032 The bench SHALL cover: add R0,R1 with R0=5, R1=3 -> R0=8, Z=0, Done in T5.
REQ-033 The bench SHALL cover: sub R0,R1 with R0=3, R1=3 -> R0=0, Z=1; a following mvnz R2,R1 -> R2 unchanged.
REQ-034 The bench SHALL cover: with PROC_CARRY_FLAG_EN, add 0xFFFF+1 -> R0=0, C=1, and mvnc R3,R1 leaves R3 unchanged; without the macro, mvnc leaves R3 unchanged.
REQ-035 The bench SHALL cover: st R0,[R1] with R0=0xAA, R1=0x40 -> ADDR=0x40, DOUT=0xAA, W=1 for exactly one cycle; a following ld R2,[R1] -> R2=0xAA.
REQ-036 The bench SHALL cover: Resetn=0 asserted during T4 of st -> W=0, pc=PC_RST, state T0 at the next edge.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants for param_proc: opcodes, T-step encoding and bus-select codes.
package proc_pkg;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstep_e;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_MVNC = 3'b111;

    localparam int BUS_SEL_W = 4;
    typedef logic [BUS_SEL_W-1:0] bus_sel_t;

    localparam bus_sel_t SEL_R7  = 4'd7;
    localparam bus_sel_t SEL_G   = 4'd8;
    localparam bus_sel_t SEL_DIN = 4'd9;

    // Register Rn sits on bus-select code n.
    function automatic bus_sel_t sel_reg(input logic [2:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter (R7) for param_proc; a bus load wins over the fetch increment.
module pc_counter #(
    parameter int            DW     = 16,
    parameter logic [DW-1:0] PC_RST = '0
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          load,
    input  logic          incr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] pc_q;
    logic [DW-1:0] pc_d;

    // Next pc: load first, then increment, else hold.
    always_comb begin
        if (load) begin
            pc_d = d;
        end else if (incr) begin
            pc_d = pc_q + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // pc register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pc_q <= PC_RST;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/param_proc.sv
// Simple multi-cycle processor: 8 x DW registers (R7 = pc), single shared bus.
// Optional carry flag and mvnc support under macro PROC_CARRY_FLAG_EN.
module param_proc
    import proc_pkg::*;
#(
    parameter int            DW     = 16,
    parameter logic [DW-1:0] PC_RST = '0
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT,
    output logic [DW-1:0] ADDR,
    output logic          W,
    output logic          Done
);

    tstep_e        state_q, state_d;
    logic [8:0]    ir_q, ir_d;
    logic [DW-1:0] r_q [0:6];
    logic [DW-1:0] r_d [0:6];
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] g_q, g_d;
    logic          z_q, z_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          w_q, w_d;
`ifdef PROC_CARRY_FLAG_EN
    logic          c_q, c_d;
    logic [DW:0]   alu_s;
`else
    logic [DW-1:0] alu_s;
`endif

    logic [2:0]    op_s, rx_s, ry_s;
    bus_sel_t      bus_sel_s;
    logic [DW-1:0] bus_s;
    logic [DW-1:0] r7_s;
    logic          done_s, wr_en_s, pc_inc_s, pc_ld_s;
    logic          ir_ld_s, a_ld_s, g_ld_s, addr_ld_s, dout_ld_s, alu_sub_s;

    assign op_s = ir_q[8:6];
    assign rx_s = ir_q[5:3];
    assign ry_s = ir_q[2:0];

    // Control: next T-step, bus source and per-register load enables.
    always_comb begin
        state_d   = state_q;
        bus_sel_s = SEL_DIN;
        done_s    = 1'b0;
        wr_en_s   = 1'b0;
        pc_inc_s  = 1'b0;
        ir_ld_s   = 1'b0;
        a_ld_s    = 1'b0;
        g_ld_s    = 1'b0;
        addr_ld_s = 1'b0;
        dout_ld_s = 1'b0;
        w_d       = 1'b0;
        alu_sub_s = (op_s == OP_SUB);
        case (state_q)
            T0: begin
                bus_sel_s = SEL_R7;
                addr_ld_s = 1'b1;
                if (Run) begin
                    pc_inc_s = 1'b1;
                    state_d  = T1;
                end else begin
                    state_d  = T0;
                end
            end
            // Reloading ADDR with the incremented pc makes DIN hold the mvi immediate in T3.
            T1: begin
                bus_sel_s = SEL_R7;
                addr_ld_s = 1'b1;
                state_d   = T2;
            end
            T2: begin
                ir_ld_s = 1'b1;
                state_d = T3;
            end
            T3: begin
                case (op_s)
                    OP_MV: begin
                        bus_sel_s = sel_reg(ry_s);
                        wr_en_s   = 1'b1;
                        done_s    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel_s = SEL_DIN;
                        wr_en_s   = 1'b1;
                        pc_inc_s  = 1'b1;
                        done_s    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel_s = sel_reg(rx_s);
                        a_ld_s    = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        bus_sel_s = sel_reg(ry_s);
                        addr_ld_s = 1'b1;
                    end
                    OP_MVNZ: begin
                        bus_sel_s = sel_reg(ry_s);
                        wr_en_s   = ~z_q;
                        done_s    = 1'b1;
                    end
                    OP_MVNC: begin
`ifdef PROC_CARRY_FLAG_EN
                        bus_sel_s = sel_reg(ry_s);
                        wr_en_s   = ~c_q;
`else
                        wr_en_s   = 1'b0;
`endif
                        done_s    = 1'b1;
                    end
                    default: begin
                        done_s = 1'b1;
                    end
                endcase
                state_d = done_s ? T0 : T4;
            end
            T4: begin
                case (op_s)
                    OP_ADD, OP_SUB: begin
                        bus_sel_s = sel_reg(ry_s);
                        g_ld_s    = 1'b1;
                    end
                    OP_ST: begin
                        bus_sel_s = sel_reg(rx_s);
                        dout_ld_s = 1'b1;
                        w_d       = 1'b1;
                    end
                    default: begin
                        bus_sel_s = SEL_DIN;
                    end
                endcase
                state_d = T5;
            end
            T5: begin
                case (op_s)
                    OP_ADD, OP_SUB: begin
                        bus_sel_s = SEL_G;
                        wr_en_s   = 1'b1;
                    end
                    OP_LD: begin
                        bus_sel_s = SEL_DIN;
                        wr_en_s   = 1'b1;
                    end
                    default: begin
                        wr_en_s = 1'b0;
                    end
                endcase
                done_s  = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

    // Shared bus: exactly one source, DIN when nothing else is selected.
    always_comb begin
        case (bus_sel_s)
            4'd0:    bus_s = r_q[0];
            4'd1:    bus_s = r_q[1];
            4'd2:    bus_s = r_q[2];
            4'd3:    bus_s = r_q[3];
            4'd4:    bus_s = r_q[4];
            4'd5:    bus_s = r_q[5];
            4'd6:    bus_s = r_q[6];
            SEL_R7:  bus_s = r7_s;
            SEL_G:   bus_s = g_q;
            default: bus_s = DIN;
        endcase
    end

    // Datapath next values: ALU wraps modulo 2^DW; flags update only when G loads.
    always_comb begin
`ifdef PROC_CARRY_FLAG_EN
        if (alu_sub_s) begin
            alu_s = {1'b0, a_q} - {1'b0, bus_s};
        end else begin
            alu_s = {1'b0, a_q} + {1'b0, bus_s};
        end
        c_d = g_ld_s ? alu_s[DW] : c_q;
`else
        if (alu_sub_s) begin
            alu_s = a_q - bus_s;
        end else begin
            alu_s = a_q + bus_s;
        end
`endif
        ir_d   = ir_ld_s   ? DIN[8:0]        : ir_q;
        a_d    = a_ld_s    ? bus_s           : a_q;
        g_d    = g_ld_s    ? alu_s[DW-1:0]   : g_q;
        z_d    = g_ld_s    ? (alu_s[DW-1:0] == {DW{1'b0}}) : z_q;
        addr_d = addr_ld_s ? bus_s           : addr_q;
        dout_d = dout_ld_s ? bus_s           : dout_q;
    end

    // Register-file write-back; Rx = R7 is routed to the pc as a load.
    always_comb begin
        pc_ld_s = wr_en_s && (rx_s == 3'd7);
        for (int i = 0; i < 7; i++) begin
            r_d[i] = (wr_en_s && (rx_s == 3'(i))) ? bus_s : r_q[i];
        end
    end

    pc_counter #(
        .DW     (DW),
        .PC_RST (PC_RST)
    ) u_pc (
        .Clock  (Clock),
        .Resetn (Resetn),
        .load   (pc_ld_s),
        .incr   (pc_inc_s),
        .d      (bus_s),
        .q      (r7_s)
    );

    // State, outputs and flags reset; R0..R6, A, G and IR are left unreset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= T0;
            addr_q  <= {DW{1'b0}};
            dout_q  <= {DW{1'b0}};
            w_q     <= 1'b0;
            z_q     <= 1'b0;
`ifdef PROC_CARRY_FLAG_EN
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            w_q     <= w_d;
            z_q     <= z_d;
`ifdef PROC_CARRY_FLAG_EN
            c_q     <= c_d;
`endif
        end
        ir_q <= ir_d;
        a_q  <= a_d;
        g_q  <= g_d;
        r_q  <= r_d;
    end

    assign ADDR = addr_q;
    assign DOUT = dout_q;
    assign W    = w_q;
    assign Done = done_s;

endmodule

// File: tb/tb_param_proc.sv
// Scoreboard bench for param_proc: runs a small program from a bench memory model.
module tb_param_proc;

    localparam int            DW     = 16;
    localparam logic [DW-1:0] PC_RST = 16'h0000;

    localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] LD = 3'b100, ST = 3'b101, MVNZ = 3'b110, MVNC = 3'b111;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Run;
    logic [DW-1:0] DIN;
    logic [DW-1:0] DOUT;
    logic [DW-1:0] ADDR;
    logic          W;
    logic          Done;

    param_proc #(.DW(DW), .PC_RST(PC_RST)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .DOUT   (DOUT),
        .ADDR   (ADDR),
        .W      (W),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] mem [0:255];
    int            w_total = 0;
    logic [DW-1:0] w_addr = '0;
    logic [DW-1:0] w_dout = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    // Synchronous memory: one-cycle read latency from the registered ADDR.
    always @(posedge Clock) begin
        DIN <= mem[ADDR[7:0]];
        if (W === 1'b1) mem[ADDR[7:0]] <= DOUT;
    end

    // Count write-enable cycles and capture the write address and data.
    always @(negedge Clock) begin
        if (W === 1'b1) begin
            w_total <= w_total + 1;
            w_addr  <= ADDR;
            w_dout  <= DOUT;
        end
    end

    typedef struct {
        int            cyc;
        int            dst;
        logic [DW-1:0] val;
        int            pc;
        int            z;
        int            c;
        int            wn;
        logic [DW-1:0] waddr;
        logic [DW-1:0] wdout;
    } exp_t;

    exp_t plan[$];
    exp_t sb[$];

    function automatic exp_t mk(int cyc, int dst, logic [DW-1:0] val, int pc, int z, int c,
                                int wn, logic [DW-1:0] waddr, logic [DW-1:0] wdout);
        exp_t e;
        e.cyc = cyc; e.dst = dst; e.val = val; e.pc = pc; e.z = z; e.c = c;
        e.wn = wn; e.waddr = waddr; e.wdout = wdout;
        return e;
    endfunction

    function automatic logic [DW-1:0] enc(logic [2:0] op, logic [2:0] x, logic [2:0] y);
        return {7'd0, op, x, y};
    endfunction

    function automatic logic [DW-1:0] rd(int i);
        case (i)
            0:       return dut.r_q[0];
            1:       return dut.r_q[1];
            2:       return dut.r_q[2];
            3:       return dut.r_q[3];
            4:       return dut.r_q[4];
            5:       return dut.r_q[5];
            6:       return dut.r_q[6];
            default: return dut.r7_s;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one instruction (Run held high), wait for Done, then score the result.
    task automatic run_one(input int idx, input exp_t e);
        int    cyc;
        int    w0;
        exp_t  got;
        string t;
        w0 = w_total;
        sb.push_back(e);
        cyc = 0;
        do begin
            @(negedge Clock);
            cyc++;
        end while (Done !== 1'b1 && cyc < 12);
        @(posedge Clock);
        #1;
        got = sb.pop_front();
        t = $sformatf("instr%0d", idx);
        check_eq({t, "_cycles"}, 32'(cyc), 32'(got.cyc));
        if (got.dst >= 0) check_eq({t, "_reg"}, 32'(rd(got.dst)), 32'(got.val));
        if (got.pc >= 0)  check_eq({t, "_pc"}, 32'(rd(7)), 32'(got.pc));
        if (got.z >= 0)   check_eq({t, "_z"}, 32'(dut.z_q), 32'(got.z));
`ifdef PROC_CARRY_FLAG_EN
        if (got.c >= 0)   check_eq({t, "_c"}, 32'(dut.c_q), 32'(got.c));
`endif
        check_eq({t, "_wcycles"}, 32'(w_total - w0), 32'(got.wn));
        if (got.wn > 0) begin
            check_eq({t, "_waddr"}, 32'(w_addr), 32'(got.waddr));
            check_eq({t, "_wdout"}, 32'(w_dout), 32'(got.wdout));
        end
    endtask

    initial begin
        logic [DW-1:0] mvnc_r4;
        int            w_snap;
`ifdef PROC_CARRY_FLAG_EN
        mvnc_r4 = 16'h0040;
`else
        mvnc_r4 = 16'h0055;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]  = enc(MVI, 3'd0, 3'd0);  mem[1]  = 16'h0005;
        mem[2]  = enc(MVI, 3'd1, 3'd0);  mem[3]  = 16'h0003;
        mem[4]  = enc(ADD, 3'd0, 3'd1);
        mem[5]  = enc(MVI, 3'd0, 3'd0);  mem[6]  = 16'h0003;
        mem[7]  = enc(SUB, 3'd0, 3'd1);
        mem[8]  = enc(MVI, 3'd2, 3'd0);  mem[9]  = 16'h0077;
        mem[10] = enc(MVNZ, 3'd2, 3'd1);
        mem[11] = enc(MVI, 3'd0, 3'd0);  mem[12] = 16'hFFFF;
        mem[13] = enc(MVI, 3'd1, 3'd0);  mem[14] = 16'h0001;
        mem[15] = enc(ADD, 3'd0, 3'd1);
        mem[16] = enc(MVI, 3'd3, 3'd0);  mem[17] = 16'h0055;
        mem[18] = enc(MVNC, 3'd3, 3'd1);
        mem[19] = enc(MV, 3'd4, 3'd3);
        mem[20] = enc(MVI, 3'd0, 3'd0);  mem[21] = 16'h00AA;
        mem[22] = enc(MVI, 3'd1, 3'd0);  mem[23] = 16'h0040;
        mem[24] = enc(ST, 3'd0, 3'd1);
        mem[25] = enc(LD, 3'd2, 3'd1);
        mem[26] = enc(ADD, 3'd2, 3'd1);
        mem[27] = enc(MVNC, 3'd4, 3'd1);
        mem[28] = enc(MVNZ, 3'd5, 3'd2);
        mem[29] = enc(MVI, 3'd7, 3'd0);  mem[30] = 16'h0020;
        mem[32] = enc(MVI, 3'd6, 3'd0);  mem[33] = 16'h0011;
        mem[34] = enc(ST, 3'd0, 3'd1);

        //                cyc dst val       pc  z   c  wn waddr     wdout
        plan.push_back(mk(4,  0, 16'h0005,  2, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  1, 16'h0003,  4, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(6,  0, 16'h0008,  5,  0,  0, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  0, 16'h0003,  7, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(6,  0, 16'h0000,  8,  1,  0, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  2, 16'h0077, 10,  1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  2, 16'h0077, 11, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  0, 16'hFFFF, 13, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  1, 16'h0001, 15, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(6,  0, 16'h0000, 16,  1,  1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  3, 16'h0055, 18, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  3, 16'h0055, 19, -1,  1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  4, 16'h0055, 20, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  0, 16'h00AA, 22, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  1, 16'h0040, 24, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(6, -1, 16'h0000, 25, -1, -1, 1, 16'h0040, 16'h00AA));
        plan.push_back(mk(6,  2, 16'h00AA, 26, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(6,  2, 16'h00EA, 27,  0,  0, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  4, mvnc_r4,  28, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  5, 16'h00EA, 29, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  7, 16'h0020, -1, -1, -1, 0, 16'h0000, 16'h0000));
        plan.push_back(mk(4,  6, 16'h0011, 34, -1, -1, 0, 16'h0000, 16'h0000));

        Resetn = 1'b0;
        Run    = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_eq("rst_state", 32'(dut.state_q), 32'd0);
        check_eq("rst_pc",    32'(rd(7)),       32'(PC_RST));
        check_eq("rst_w",     32'(W),           32'd0);
        check_eq("rst_addr",  32'(ADDR),        32'd0);
        check_eq("rst_dout",  32'(DOUT),        32'd0);
        check_eq("rst_z",     32'(dut.z_q),     32'd0);
        check_eq("rst_done",  32'(Done),        32'd0);
`ifdef PROC_CARRY_FLAG_EN
        check_eq("rst_c",     32'(dut.c_q),     32'd0);
`endif
        Resetn = 1'b1;
        Run    = 1'b1;

        for (int i = 0; i < plan.size(); i++) run_one(i, plan[i]);

        // st at address 34: reset lands in its T4, before W can rise.
        w_snap = w_total;
        repeat (5) @(negedge Clock);
        check_eq("st_in_t4", 32'(dut.state_q), 32'd4);
        Resetn = 1'b0;
        @(posedge Clock);
        #1;
        check_eq("abort_w",     32'(W),           32'd0);
        check_eq("abort_pc",    32'(rd(7)),       32'(PC_RST));
        check_eq("abort_state", 32'(dut.state_q), 32'd0);
        check_eq("abort_dout",  32'(DOUT),        32'd0);
        check_eq("abort_addr",  32'(ADDR),        32'd0);
        check_eq("abort_done",  32'(Done),        32'd0);
        check_eq("abort_wcnt",  32'(w_total - w_snap), 32'd0);
        Resetn = 1'b1;
        run_one(99, mk(4, 0, 16'h0005, 2, -1, -1, 0, 16'h0000, 16'h0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
